// File: rtl/dbg_guv_pkg.sv
// Shared types and constants for the debug command sequencer.
// Covers the opcode and state enums, the error codes and the command field offsets.
package dbg_guv_pkg;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 4;
  localparam int CH_LSB  = 4;
  localparam int CH_W    = 4;
  localparam int ARG_LSB = 8;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_PAUSE   = 4'd1,
    OP_UNPAUSE = 4'd2,
    OP_DROP    = 4'd3,
    OP_UNDROP  = 4'd4,
    OP_INJECT  = 4'd5,
    OP_LOG     = 4'd6,
    OP_UNLOG   = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ERROR     = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_BAD_CH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/dbg_cmd_decode.sv
// Combinational opcode and channel validity decode for incoming commands.
module dbg_cmd_decode
  import dbg_guv_pkg::*;
#(
  parameter int NUM_CH = 5
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [CH_W-1:0]   ch_idx,
  output logic              is_nop,
  output logic              op_ok,
  output logic              ch_ok,
  output logic [NUM_CH-1:0] ch_onehot
);

  always_comb begin
    is_nop = (opcode == OP_NOP);
    op_ok  = (opcode <= OP_UNLOG);
    ch_ok  = (int'(ch_idx) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_onehot[i] = (int'(ch_idx) == i);
    end
  end

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// Debug command sequencer: accepts stream commands, issues channel actions, tracks sticky masks.
// Optional WAIT_DONE timeout is enabled with macro DBG_CMD_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | ready for a command; bounded drops watch for exhaustion
// ISSUE        | act_valid high for one cycle
// WAIT_DONE    | waiting for act_done of the selected channel
// ERROR        | one-cycle err pulse with err_code loaded
module dbg_cmd_sequencer
  import dbg_guv_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int ARG_W  = 16,
  parameter int TMO_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_tdata,
  input  logic              cmd_tvalid,
  output logic              cmd_tready,
  output logic              act_valid,
  output logic [3:0]        act_op,
  output logic [NUM_CH-1:0] act_ch,
  output logic [ARG_W-1:0]  act_arg,
  input  logic [NUM_CH-1:0] act_done,
  output logic [NUM_CH-1:0] pause_mask,
  output logic [NUM_CH-1:0] drop_mask,
  output logic [NUM_CH-1:0] log_mask,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  state_e            state, state_nxt;
  logic [1:0]        err_val;
  logic              is_nop, op_ok, ch_ok, accept, done_sel, timeout;
  logic [NUM_CH-1:0] ch_onehot, drop_bounded;
  logic              unused_tdata;

  assign unused_tdata = ^(cmd_tdata >> (ARG_LSB + ARG_W));

  dbg_cmd_decode #(.NUM_CH(NUM_CH)) u_decode (
    .opcode    (cmd_tdata[OPC_LSB +: OPC_W]),
    .ch_idx    (cmd_tdata[CH_LSB +: CH_W]),
    .is_nop    (is_nop),
    .op_ok     (op_ok),
    .ch_ok     (ch_ok),
    .ch_onehot (ch_onehot)
  );

  assign accept   = cmd_tvalid && cmd_tready;
  assign done_sel = |(act_done & act_ch);

`ifdef DBG_CMD_TIMEOUT_EN
  // Loaded in ISSUE so the terminal count lands on the (2^TMO_W-1)th WAIT_DONE cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else if (state == ST_ISSUE) tmo_cnt <= TMO_LOAD;
    else if (state == ST_WAIT_DONE && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign timeout = (state == ST_WAIT_DONE) && (tmo_cnt == '0);
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_val   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_nop) begin
            state_nxt = ST_IDLE;
          end else if (!op_ok) begin
            state_nxt = ST_ERROR;
            err_val   = ERR_BAD_OP;
          end else if (!ch_ok) begin
            state_nxt = ST_ERROR;
            err_val   = ERR_BAD_CH;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_sel) begin
          state_nxt = ST_IDLE;
        end else if (timeout) begin
          state_nxt = ST_ERROR;
          err_val   = ERR_TIMEOUT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_tready = (state == ST_IDLE);
    act_valid  = (state == ST_ISSUE);
    err        = (state == ST_ERROR);
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_op       <= '0;
      act_ch       <= '0;
      act_arg      <= '0;
      err_code     <= ERR_NONE;
      pause_mask   <= '0;
      drop_mask    <= '0;
      log_mask     <= '0;
      drop_bounded <= '0;
    end else begin
      if (accept && state_nxt == ST_ISSUE) begin
        act_op  <= cmd_tdata[OPC_LSB +: OPC_W];
        act_ch  <= ch_onehot;
        act_arg <= cmd_tdata[ARG_LSB +: ARG_W];
      end
      if (state_nxt == ST_ERROR) err_code <= err_val;
      if (state == ST_WAIT_DONE && done_sel) begin
        case (act_op)
          OP_PAUSE:   pause_mask <= pause_mask | act_ch;
          OP_UNPAUSE: pause_mask <= pause_mask & ~act_ch;
          OP_LOG:     log_mask   <= log_mask | act_ch;
          OP_UNLOG:   log_mask   <= log_mask & ~act_ch;
          OP_DROP: begin
            drop_mask <= drop_mask | act_ch;
            if (act_arg != '0) drop_bounded <= drop_bounded | act_ch;
            else               drop_bounded <= drop_bounded & ~act_ch;
          end
          OP_UNDROP: begin
            drop_mask    <= drop_mask & ~act_ch;
            drop_bounded <= drop_bounded & ~act_ch;
          end
          default: ;
        endcase
      end else if (state == ST_IDLE) begin
        // A later act_done on a bounded-drop channel means its drop count ran out.
        drop_mask    <= drop_mask & ~(act_done & drop_bounded);
        drop_bounded <= drop_bounded & ~act_done;
      end
    end
  end

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Directed self-checking bench for dbg_cmd_sequencer.
module tb_dbg_cmd_sequencer;
  localparam int NUM_CH = 5;
  localparam int ARG_W  = 16;
  localparam int TMO_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       cmd_tdata = '0;
  logic              cmd_tvalid = 1'b0;
  logic              cmd_tready;
  logic              act_valid;
  logic [3:0]        act_op;
  logic [NUM_CH-1:0] act_ch;
  logic [ARG_W-1:0]  act_arg;
  logic [NUM_CH-1:0] act_done = '0;
  logic [NUM_CH-1:0] pause_mask, drop_mask, log_mask;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dbg_cmd_sequencer #(.NUM_CH(NUM_CH), .ARG_W(ARG_W), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .act_valid  (act_valid),
    .act_op     (act_op),
    .act_ch     (act_ch),
    .act_arg    (act_arg),
    .act_done   (act_done),
    .pause_mask (pause_mask),
    .drop_mask  (drop_mask),
    .log_mask   (log_mask),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns one step after the accepting edge.
  task automatic send_cmd(input logic [31:0] d);
    int n = 0;
    cmd_tdata  = d;
    cmd_tvalid = 1'b1;
    while (!cmd_tready && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (cmd_tready !== 1'b1) begin
      n_mis++;
      $display("FAIL send_cmd_ready cmd=%h tready=%b required 1", d, cmd_tready);
    end
    step();
    cmd_tvalid = 1'b0;
  endtask

  // From ISSUE: act_done[ch] during the first WAIT_DONE cycle.
  task automatic finish_cmd(input int ch);
    step();
    act_done = NUM_CH'(1 << ch);
    step();
    act_done = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (cmd_tready !== 1'b1) begin n_mis++; $display("FAIL reset_tready act=%b req=1", cmd_tready); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy act=%b req=0", busy); end
    n_cmp++; if (act_valid !== 1'b0) begin n_mis++; $display("FAIL reset_act_valid act=%b req=0", act_valid); end
    n_cmp++; if ({pause_mask, drop_mask, log_mask} !== 15'd0) begin n_mis++; $display("FAIL reset_masks act=%b/%b/%b req=0", pause_mask, drop_mask, log_mask); end
    n_cmp++; if ({err, err_code} !== 3'd0) begin n_mis++; $display("FAIL reset_err act=%b/%d req=0/0", err, err_code); end
    n_cmp++; if ({act_op, act_ch, act_arg} !== 25'd0) begin n_mis++; $display("FAIL reset_act_fields act=%h/%b/%h req=0", act_op, act_ch, act_arg); end
  endtask

  task automatic test_pause();
    send_cmd(32'h0000_0021);
    n_cmp++; if (act_valid !== 1'b1) begin n_mis++; $display("FAIL pause_act_valid act=%b req=1", act_valid); end
    n_cmp++; if (act_ch !== 5'b00100) begin n_mis++; $display("FAIL pause_act_ch act=%b req=00100", act_ch); end
    n_cmp++; if (act_op !== 4'd1) begin n_mis++; $display("FAIL pause_act_op act=%d req=1", act_op); end
    n_cmp++; if (cmd_tready !== 1'b0) begin n_mis++; $display("FAIL pause_tready_issue act=%b req=0", cmd_tready); end
    act_done = 5'b00100;
    step();
    act_done = 5'b00001;
    n_cmp++; if (act_valid !== 1'b0) begin n_mis++; $display("FAIL pause_act_valid_drop act=%b req=0", act_valid); end
    step();
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL pause_busy_wait act=%b req=1", busy); end
    n_cmp++; if (pause_mask !== 5'b00000) begin n_mis++; $display("FAIL pause_mask_early act=%b req=00000", pause_mask); end
    act_done = 5'b00100;
    step();
    act_done = '0;
    n_cmp++; if (pause_mask !== 5'b00100) begin n_mis++; $display("FAIL pause_mask act=%b req=00100", pause_mask); end
    n_cmp++; if ({cmd_tready, busy} !== 2'b10) begin n_mis++; $display("FAIL pause_idle act=%b%b req=10", cmd_tready, busy); end
  endtask

  task automatic test_bad_opcode();
    send_cmd(32'h0000_0009);
    n_cmp++; if ({err, err_code} !== 3'b101) begin n_mis++; $display("FAIL badop_err act=%b/%d req=1/1", err, err_code); end
    n_cmp++; if (act_valid !== 1'b0) begin n_mis++; $display("FAIL badop_act_valid act=%b req=0", act_valid); end
    step();
    n_cmp++; if ({err, err_code} !== 3'b001) begin n_mis++; $display("FAIL badop_err_hold act=%b/%d req=0/1", err, err_code); end
    n_cmp++; if ({pause_mask, drop_mask, log_mask} !== 15'b00100_00000_00000) begin n_mis++; $display("FAIL badop_masks act=%b/%b/%b", pause_mask, drop_mask, log_mask); end
  endtask

  task automatic test_bad_channel();
    send_cmd(32'h0000_0071);
    n_cmp++; if ({err, err_code, cmd_tready} !== 4'b1100) begin n_mis++; $display("FAIL badch_err act=%b/%d/%b req=1/2/0", err, err_code, cmd_tready); end
    step();
    n_cmp++; if ({err, err_code, cmd_tready} !== 4'b0101) begin n_mis++; $display("FAIL badch_recover act=%b/%d/%b req=0/2/1", err, err_code, cmd_tready); end
  endtask

  task automatic test_nop();
    send_cmd(32'h0000_0000);
    n_cmp++; if ({cmd_tready, busy, act_valid, err} !== 4'b1000) begin n_mis++; $display("FAIL nop_idle act=%b%b%b%b req=1000", cmd_tready, busy, act_valid, err); end
  endtask

  task automatic test_unpause();
    send_cmd(32'h0000_0002);
    finish_cmd(0);
    n_cmp++; if ({cmd_tready, pause_mask} !== 6'b1_00100) begin n_mis++; $display("FAIL unpause_idem act=%b/%b req=1/00100", cmd_tready, pause_mask); end
    send_cmd(32'h0000_0022);
    finish_cmd(2);
    n_cmp++; if (pause_mask !== 5'b00000) begin n_mis++; $display("FAIL unpause_clear act=%b req=00000", pause_mask); end
  endtask

  task automatic test_drop_bounded();
    send_cmd(32'h0000_0313);
    n_cmp++; if ({act_op, act_ch, act_arg} !== {4'd3, 5'b00010, 16'd3}) begin n_mis++; $display("FAIL drop_fields act=%d/%b/%h req=3/00010/0003", act_op, act_ch, act_arg); end
    finish_cmd(1);
    n_cmp++; if (drop_mask !== 5'b00010) begin n_mis++; $display("FAIL drop_set act=%b req=00010", drop_mask); end
    act_done = 5'b00001;
    step();
    act_done = '0;
    step();
    n_cmp++; if (drop_mask !== 5'b00010) begin n_mis++; $display("FAIL drop_other_ch act=%b req=00010", drop_mask); end
    act_done = 5'b00010;
    step();
    act_done = '0;
    n_cmp++; if (drop_mask !== 5'b00000) begin n_mis++; $display("FAIL drop_exhaust act=%b req=00000", drop_mask); end
  endtask

  task automatic test_drop_unbounded();
    send_cmd(32'h0000_0043);
    finish_cmd(4);
    act_done = 5'b10000;
    step();
    act_done = '0;
    n_cmp++; if (drop_mask !== 5'b10000) begin n_mis++; $display("FAIL drop_unbounded act=%b req=10000", drop_mask); end
    send_cmd(32'h0000_0044);
    finish_cmd(4);
    n_cmp++; if (drop_mask !== 5'b00000) begin n_mis++; $display("FAIL undrop act=%b req=00000", drop_mask); end
  endtask

  task automatic test_log_inject();
    send_cmd(32'h0000_0036);
    finish_cmd(3);
    n_cmp++; if (log_mask !== 5'b01000) begin n_mis++; $display("FAIL log_set act=%b req=01000", log_mask); end
    send_cmd(32'h0000_5A35);
    n_cmp++; if ({act_op, act_arg} !== {4'd5, 16'h005A}) begin n_mis++; $display("FAIL inject_fields act=%d/%h req=5/005a", act_op, act_arg); end
    finish_cmd(3);
    n_cmp++; if ({pause_mask, drop_mask, log_mask} !== 15'b00000_00000_01000) begin n_mis++; $display("FAIL inject_masks act=%b/%b/%b", pause_mask, drop_mask, log_mask); end
    send_cmd(32'h0000_0037);
    finish_cmd(3);
    n_cmp++; if (log_mask !== 5'b00000) begin n_mis++; $display("FAIL unlog act=%b req=00000", log_mask); end
  endtask

  task automatic test_wait_timeout();
`ifdef DBG_CMD_TIMEOUT_EN
    send_cmd(32'h0000_0006);
    repeat (15) step();
    n_cmp++; if ({busy, err} !== 2'b10) begin n_mis++; $display("FAIL tmo_early act=%b%b req=10", busy, err); end
    step();
    n_cmp++; if ({err, err_code} !== 3'b111) begin n_mis++; $display("FAIL tmo_err act=%b/%d req=1/3", err, err_code); end
    step();
    n_cmp++; if ({cmd_tready, log_mask} !== 6'b1_00000) begin n_mis++; $display("FAIL tmo_after act=%b/%b req=1/00000", cmd_tready, log_mask); end
`else
    send_cmd(32'h0000_0006);
    repeat (40) step();
    n_cmp++; if ({busy, err, cmd_tready} !== 3'b100) begin n_mis++; $display("FAIL notmo_wait act=%b%b%b req=100", busy, err, cmd_tready); end
    act_done = 5'b00001;
    step();
    act_done = '0;
    n_cmp++; if ({cmd_tready, log_mask, err_code} !== 8'b1_00001_10) begin n_mis++; $display("FAIL notmo_done act=%b/%b/%d req=1/00001/2", cmd_tready, log_mask, err_code); end
    send_cmd(32'h0000_0007);
    finish_cmd(0);
`endif
  endtask

  task automatic test_reset_mid();
    send_cmd(32'h0000_0016);
    finish_cmd(1);
    send_cmd(32'h0000_0033);
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, act_valid, err, err_code} !== 5'd0) begin n_mis++; $display("FAIL rstmid_ctrl act=%b%b%b/%d req=0", busy, act_valid, err, err_code); end
    n_cmp++; if ({pause_mask, drop_mask, log_mask} !== 15'd0) begin n_mis++; $display("FAIL rstmid_masks act=%b/%b/%b req=0", pause_mask, drop_mask, log_mask); end
    n_cmp++; if ({act_op, act_ch, act_arg} !== 25'd0) begin n_mis++; $display("FAIL rstmid_fields act=%h/%b/%h req=0", act_op, act_ch, act_arg); end
    step();
    rst = 1'b0;
    act_done = 5'b01000;
    step();
    act_done = '0;
    step();
    n_cmp++; if ({cmd_tready, busy, err, drop_mask} !== 8'b100_00000) begin n_mis++; $display("FAIL rstmid_after act=%b%b%b/%b req=100/00000", cmd_tready, busy, err, drop_mask); end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_bad_opcode();
    test_bad_channel();
    test_nop();
    test_unpause();
    test_drop_bounded();
    test_drop_unbounded();
    test_log_inject();
    test_wait_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_sequencer.md
DBG_CMD_SEQUENCER -- requirements
Module: dbg_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of governed AXI channels (AR, R, AW, W, B).
REQ-002 SHALL have parameter ARG_W, default 16, command argument width.
REQ-003 SHALL have parameter TMO_W, default 12, done-timeout counter width.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_tdata  in  32  command: [3:0] opcode, [7:4] channel index, [7+ARG_W:8] argument.
REQ-007 cmd_tvalid  in  1 / cmd_tready  out  1  AXI-Stream command handshake.
REQ-008 act_valid  out  1  action request pending to channel logic.
REQ-009 act_op  out  4 / act_ch  out  NUM_CH (one-hot) / act_arg  out  ARG_W  registered action fields.
REQ-010 act_done  in  NUM_CH  per-channel completion pulse.
REQ-011 pause_mask, drop_mask, log_mask  out  NUM_CH each  sticky per-channel mode bits.
REQ-012 err  out  1  one-cycle pulse; err_code  out  2  (1 bad opcode, 2 bad channel, 3 timeout), held until next error.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 Opcodes SHALL be: 0 NOP, 1 PAUSE, 2 UNPAUSE, 3 DROP, 4 UNDROP, 5 INJECT, 6 LOG, 7 UNLOG; 8-15 invalid.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, ERROR.
REQ-016 cmd_tready SHALL be 1 only in IDLE; a command is accepted when cmd_tvalid && cmd_tready.
REQ-017 On accept: NOP stays IDLE; invalid opcode or channel index >= NUM_CH goes ERROR; otherwise cmd fields are registered and FSM goes ISSUE.
REQ-018 ISSUE SHALL assert act_valid for exactly one cycle, then go WAIT_DONE.
REQ-019 WAIT_DONE SHALL return to IDLE on the cycle act_done[sel] is 1; act_done bits of other channels SHALL be ignored.
REQ-020 act_done[sel] arriving in the same cycle as act_valid SHALL be ignored; completion counts from the cycle after ISSUE.
REQ-021 On completion the mask bit of the selected channel SHALL update: PAUSE sets / UNPAUSE clears pause_mask, DROP sets / UNDROP clears drop_mask, LOG sets / UNLOG clears log_mask; INJECT changes no mask.
REQ-022 DROP with argument 0 SHALL set drop_mask (unbounded); argument N>0 SHALL be forwarded in act_arg and drop_mask cleared when channel signals act_done a second time while IDLE (count exhausted).
REQ-023 UNPAUSE on a channel not paused SHALL still issue and complete normally (idempotent).
REQ-024 ERROR SHALL pulse err for one cycle, load err_code, and return to IDLE next cycle; masks unchanged.
REQ-025 Command-to-act_valid latency SHALL be 1 cycle after accept; minimum command-to-next-tready 3 cycles.

Reset
REQ-026 On rst: state IDLE, cmd_tready 1 after release, act_valid 0, act_op/act_ch/act_arg 0, all masks 0, err 0, err_code 0, busy 0, timeout counter 0.
REQ-027 rst mid-command SHALL abandon the command with no mask update and no err pulse.

Configuration
REQ-028 Macro DBG_CMD_TIMEOUT_EN defined: WAIT_DONE counts cycles; at 2^TMO_W-1 without act_done[sel] the FSM SHALL go ERROR with err_code 3.
REQ-029 Macro undefined: no counter; WAIT_DONE waits indefinitely; err_code 3 never produced.

Structure
REQ-030 Opcode enum, state enum, err_code constants and command field offsets SHALL reside in package dbg_guv_pkg.
REQ-031 Opcode/channel validity decode SHALL be sub-module dbg_cmd_decode (combinational, NUM_CH-parametrised); FSM and masks in dbg_cmd_sequencer.

Verification
REQ-032 PAUSE ch2 (0x00000021), act_done[2] 2 cycles after act_valid -> act_ch=5'b00100, pause_mask=5'b00100, back to IDLE.
REQ-033 Opcode 9 on ch0 (0x00000009) -> err pulse, err_code=1, no act_valid, masks unchanged.
REQ-034 Channel 7 with NUM_CH=5 (0x00000071) -> err_code=2, cmd_tready high again 2 cycles later.
REQ-035 DROP ch1 arg 3 (0x00000313), act_done[1] on completion, later second act_done[1] -> drop_mask[1] set then cleared.
REQ-036 With DBG_CMD_TIMEOUT_EN, TMO_W=4, LOG ch0, no act_done -> err_code=3 after 15 WAIT_DONE cycles, log_mask 0.
REQ-037 rst asserted during WAIT_DONE of DROP ch3 -> all outputs at reset values, drop_mask 0.
